s_decoder_serial: RTL and testbench
===================================

// Module: s_decoder_serial
// PURPOSE
//  Serial receiver and decoder for the 5-bit S code produced by the 4-bit encoder.
//  Encoding: x<8 -> S=x+3; x>=8 -> S=x+14.
//  - Shifts in 5-bit S words one bit per accepted cycle.
//  - Decodes each word back to its 4-bit x; flags illegal codes and counts them.
//  - Presents the result on a one-entry valid/ready output register.
// PARAMETERS
//  MSB_FIRST  1  1: first accepted bit is S[4]; 0: first accepted bit is S[0]
//  ERR_W      8  width of the saturating illegal-code counter
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  frame_clr  in   1      synchronous resync: discard the partial word, bit count -> 0
//  bit_valid  in   1      bit_in is valid this cycle
//  bit_in     in   1      serial S bit
//  in_ready   out  1      block accepts bit_in this cycle
//  x_valid    out  1      x/x_err hold a decoded word
//  x_ready    in   1      consumer takes the word this cycle
//  x          out  4      decoded value (0 when x_err=1)
//  x_err      out  1      the word was an illegal S code
//  err_cnt    out  ERR_W  number of illegal words decoded, saturating
// BEHAVIOUR
//  Reset:
//   - rst=1 clears immediately (async): bit count=0, shift reg=0, x_valid=0, x=0,
//     x_err=0, err_cnt=0.
//   - A partial word is lost on reset.
//  Accept rule:
//   - A bit is accepted when bit_valid & in_ready & ~frame_clr.
//   - in_ready = (cnt!=4) | ~x_valid | x_ready.
//   - Bits 1-4 of a word are never stalled. Only the 5th bit waits for the output slot.
//  Counter:
//   - cnt runs 0..4 and increments on each accepted bit.
//   - It wraps 4->0 on the 5th accepted bit.
//   - frame_clr wins over a same-cycle bit: the bit is dropped and cnt=0.
//   - frame_clr does not touch the output register.
//  Assembly:
//   - MSB_FIRST=1: shift left, new bit into S[0].
//   - MSB_FIRST=0: shift right, new bit into S[4].
//  Decode (combinational on the completed 5-bit word S):
//   - S in 3..10  -> x=S-3,  err=0
//   - S in 22..29 -> x=S-14, err=0
//   - any other S (0-2, 11-21, 30, 31) -> x=0, err=1
//   - Arithmetic is 5-bit; result truncated to 4 bits.
//  Output register:
//   - Latency: x/x_err/x_valid update on the clock edge that accepts the 5th bit,
//     so they are visible 1 cycle after that bit is presented.
//   - x_valid set on 5th-bit accept.
//   - x_valid cleared when x_ready & x_valid and no 5th bit is accepted that cycle.
//   - Drain and 5th bit in the same cycle: the new word replaces the old one and
//     x_valid stays 1.
//   - x and x_err are held stable while x_valid & ~x_ready.
//  err_cnt:
//   - Increments on each 5th-bit accept whose decode has err=1.
//   - Saturates at 2^ERR_W-1.
//  Reset mid-word or mid-handshake: all state returns to reset values; no partial
//  output is emitted.
// TESTING (MSB_FIRST=1 unless noted)
//  1. Sweep x=0..15, encode serially with x_ready=1 -> x matches each value, x_err=0,
//     err_cnt=0, exactly 16 x_valid pulses.
//  2. Bits 0,1,0,1,1 (S=11) -> x_valid=1, x_err=1, x=0, err_cnt=1.
//     Bits 1,1,1,1,1 (S=31) -> err_cnt=2.
//  3. x_ready=0 after S=8 (x=5), then stream S=23:
//     - first 4 bits are accepted, in_ready=0 at the 5th, x stays 5.
//     - Raise x_ready -> 5th bit accepted, next cycle x=9.
//  4. After bits 1,1,1, assert frame_clr with bit_valid=1, then send 0,0,0,1,1
//     -> x=0, x_err=0 (the partial word and the collided bit are discarded).
//  5. Assert rst after 3 bits with x_valid=1 -> x_valid, x, err_cnt and cnt all 0
//     at once. Then S=29 -> x=15.
//  6. MSB_FIRST=0, send S=22 LSB first (0,1,1,0,1) -> x=8.
//     With ERR_W=2, feed 5 illegal words -> err_cnt=3.

Source files
------------

// File: rtl/s_decoder_serial.sv
// s_decoder_serial
// Serial receiver for the 5-bit S code (x<8 -> S=x+3, x>=8 -> S=x+14).
// It shifts in one bit per accepted cycle and decodes each completed word back to x.
// The result is held in a one-entry valid/ready output register.
// Illegal words are flagged and counted in a saturating counter.
module s_decoder_serial #(
  parameter bit MSB_FIRST = 1'b1,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             frame_clr,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             in_ready,
  output logic             x_valid,
  input  logic             x_ready,
  output logic [3:0]       x,
  output logic             x_err,
  output logic [ERR_W-1:0] err_cnt
);

  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  logic [2:0]       cnt_q, cnt_d;
  logic [4:0]       shift_q, shift_d;
  logic             x_valid_q, x_valid_d;
  logic [3:0]       x_q, x_d;
  logic             x_err_q, x_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;

  logic             accept;
  logic             last_bit;
  logic [4:0]       word_next;
  logic [4:0]       diff;
  logic [3:0]       dec_x;
  logic             dec_err;

  // Only the 5th bit of a word needs the output slot, so only it can stall.
  assign in_ready = (cnt_q != 3'd4) | ~x_valid_q | x_ready;
  assign accept   = bit_valid & in_ready & ~frame_clr;
  assign last_bit = accept & (cnt_q == 3'd4);

  // Word as it looks after shifting in the current bit; it is complete when last_bit is set.
  assign word_next = MSB_FIRST ? {shift_q[3:0], bit_in} : {bit_in, shift_q[4:1]};

  // Decode the completed word: two legal windows, everything else is illegal.
  always_comb begin
    diff    = 5'd0;
    dec_err = 1'b1;
    if (word_next >= 5'd3 && word_next <= 5'd10) begin
      diff    = word_next - 5'd3;
      dec_err = 1'b0;
    end else if (word_next >= 5'd22 && word_next <= 5'd29) begin
      diff    = word_next - 5'd14;
      dec_err = 1'b0;
    end
    dec_x = diff[3:0];
  end

  // Next-state: bit counter, shift register, output slot and error counter.
  always_comb begin
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    x_valid_d = x_valid_q;
    x_d       = x_q;
    x_err_d   = x_err_q;
    err_cnt_d = err_cnt_q;

    // A resync drops the partial word and any bit that arrives in the same cycle.
    if (frame_clr) begin
      cnt_d   = 3'd0;
      shift_d = 5'd0;
    end else if (accept) begin
      shift_d = word_next;
      cnt_d   = (cnt_q == 3'd4) ? 3'd0 : cnt_q + 3'd1;
    end

    // A new word takes priority over a drain in the same cycle, so the slot stays full.
    if (last_bit) begin
      x_valid_d = 1'b1;
      x_d       = dec_err ? 4'd0 : dec_x;
      x_err_d   = dec_err;
      if (dec_err && err_cnt_q != ERR_MAX) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
    end else if (x_valid_q && x_ready) begin
      x_valid_d = 1'b0;
    end
  end

  // State registers; reset clears everything immediately, including any partial word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q     <= 3'd0;
      shift_q   <= 5'd0;
      x_valid_q <= 1'b0;
      x_q       <= 4'd0;
      x_err_q   <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      cnt_q     <= cnt_d;
      shift_q   <= shift_d;
      x_valid_q <= x_valid_d;
      x_q       <= x_d;
      x_err_q   <= x_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign x_valid = x_valid_q;
  assign x       = x_q;
  assign x_err   = x_err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_s_decoder_serial.sv
// Scoreboard bench for s_decoder_serial.
// dut0 uses the defaults (MSB first, 8-bit counter).
// dut1 uses LSB first with a 2-bit counter.
module tb_s_decoder_serial;

  typedef struct {
    int x;
    int err;
    int ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fc, bv, bi, xr;
  logic [1:0] in_rdy, xv, xe;
  logic [3:0] x0, x1;
  logic [7:0] ec0;
  logic [1:0] ec1;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   total = 0;
  int   bad   = 0;
  int   hs0   = 0;
  int   model_ec0 = 0;
  int   model_ec1 = 0;

  always #5 clk = ~clk;

  s_decoder_serial #(.MSB_FIRST(1'b1), .ERR_W(8)) dut0 (
    .clk(clk), .rst(rst), .frame_clr(fc[0]), .bit_valid(bv[0]), .bit_in(bi[0]),
    .in_ready(in_rdy[0]), .x_valid(xv[0]), .x_ready(xr[0]), .x(x0), .x_err(xe[0]),
    .err_cnt(ec0)
  );

  s_decoder_serial #(.MSB_FIRST(1'b0), .ERR_W(2)) dut1 (
    .clk(clk), .rst(rst), .frame_clr(fc[1]), .bit_valid(bv[1]), .bit_in(bi[1]),
    .in_ready(in_rdy[1]), .x_valid(xv[1]), .x_ready(xr[1]), .x(x1), .x_err(xe[1]),
    .err_cnt(ec1)
  );

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor dut0: a word leaves on every cycle with x_valid & x_ready.
  always @(negedge clk) begin
    if (!rst && xv[0] && xr[0]) begin
      hs0++;
      if (exp_q0.size() == 0) begin
        chk("spurious_word0", exp_q0.size(), 1);
      end else begin
        exp_t e;
        e = exp_q0.pop_front();
        $display("dut0 word: x=%0d err=%0d cnt=%0d (exp %0d/%0d/%0d)",
                 x0, xe[0], ec0, e.x, e.err, e.ec);
        chk("x0", int'(x0), e.x);
        chk("x_err0", int'(xe[0]), e.err);
        chk("err_cnt0", int'(ec0), e.ec);
      end
    end
  end

  // Monitor dut1.
  always @(negedge clk) begin
    if (!rst && xv[1] && xr[1]) begin
      if (exp_q1.size() == 0) begin
        chk("spurious_word1", exp_q1.size(), 1);
      end else begin
        exp_t e;
        e = exp_q1.pop_front();
        $display("dut1 word: x=%0d err=%0d cnt=%0d (exp %0d/%0d/%0d)",
                 x1, xe[1], ec1, e.x, e.err, e.ec);
        chk("x1", int'(x1), e.x);
        chk("x_err1", int'(xe[1]), e.err);
        chk("err_cnt1", int'(ec1), e.ec);
      end
    end
  end

  task automatic push_exp(input int d, input int ex, input int er);
    exp_t e;
    e.x = ex;
    e.err = er;
    if (d == 0) begin
      if (er != 0 && model_ec0 < 255) model_ec0++;
      e.ec = model_ec0;
      exp_q0.push_back(e);
    end else begin
      if (er != 0 && model_ec1 < 3) model_ec1++;
      e.ec = model_ec1;
      exp_q1.push_back(e);
    end
  endtask

  // Present one bit and hold it until the DUT accepts it, within a bounded wait.
  task automatic send_bit(input int d, input logic b);
    bit ok;
    ok = 1'b0;
    bv[d] = 1'b1;
    bi[d] = b;
    for (int t = 0; t < 50 && !ok; t++) begin
      @(negedge clk);
      if (in_rdy[d] && !fc[d]) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    bv[d] = 1'b0;
    if (!ok) chk("accept_timeout", 0, 1);
  endtask

  task automatic send_word(input int d, input logic [4:0] s);
    logic [4:0] w;
    w = s;
    for (int i = 0; i < 5; i++) begin
      send_bit(d, (d == 0) ? w[4-i] : w[i]);
    end
  endtask

  initial begin
    logic [4:0] s;
    rst = 1'b1;
    fc = '0;
    bv = '0;
    bi = '0;
    xr = 2'b11;
    @(negedge clk);
    chk("rst_x_valid0", int'(xv[0]), 0);
    chk("rst_x0", int'(x0), 0);
    chk("rst_err_cnt0", int'(ec0), 0);
    chk("rst_x_valid1", int'(xv[1]), 0);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1: sweep all legal codes.
    for (int v = 0; v < 16; v++) begin
      s = (v < 8) ? 5'(v + 3) : 5'(v + 14);
      push_exp(0, v, 0);
      send_word(0, s);
    end
    repeat (3) @(posedge clk);
    #1 chk("sweep_pulses", hs0, 16);

    // 2: illegal codes.
    push_exp(0, 0, 1);
    send_word(0, 5'd11);
    push_exp(0, 0, 1);
    send_word(0, 5'd31);
    repeat (2) @(posedge clk);
    #1;

    // 3: stall the 5th bit behind a full output slot.
    xr[0] = 1'b0;
    push_exp(0, 5, 0);
    send_word(0, 5'd8);
    push_exp(0, 9, 0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    bv[0] = 1'b1;
    bi[0] = 1'b1;
    for (int t = 0; t < 2; t++) begin
      @(negedge clk);
      chk("stall_in_ready", int'(in_rdy[0]), 0);
      chk("stall_x_held", int'(x0), 5);
      chk("stall_x_valid", int'(xv[0]), 1);
      @(posedge clk);
      #1;
    end
    xr[0] = 1'b1;
    send_bit(0, 1'b1);
    repeat (2) @(posedge clk);
    #1;

    // 4: frame_clr discards the partial word and a colliding bit.
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    fc[0] = 1'b1;
    bv[0] = 1'b1;
    bi[0] = 1'b1;
    @(posedge clk);
    #1;
    fc[0] = 1'b0;
    bv[0] = 1'b0;
    push_exp(0, 0, 0);
    send_word(0, 5'd3);
    repeat (2) @(posedge clk);
    #1;

    // 5: asynchronous reset mid-word while a word is waiting.
    xr[0] = 1'b0;
    push_exp(0, 2, 0);
    send_word(0, 5'd5);
    send_bit(0, 1'b0);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("async_x_valid", int'(xv[0]), 0);
    chk("async_x", int'(x0), 0);
    chk("async_err_cnt", int'(ec0), 0);
    exp_q0.delete();
    model_ec0 = 0;
    @(posedge clk);
    #1 rst = 1'b0;
    xr[0] = 1'b1;
    push_exp(0, 15, 0);
    send_word(0, 5'd29);
    repeat (2) @(posedge clk);
    #1;

    // 6: LSB-first instance and a narrow saturating counter.
    model_ec1 = 0;
    push_exp(1, 8, 0);
    send_word(1, 5'd22);
    for (int k = 0; k < 5; k++) begin
      push_exp(1, 0, 1);
      send_word(1, 5'd0);
    end
    repeat (3) @(posedge clk);
    #1;
    chk("final_err_cnt1", int'(ec1), 3);
    chk("queue0_drained", exp_q0.size(), 0);
    chk("queue1_drained", exp_q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
